nivel_agua_monitor: RTL and testbench

NIVEL_AGUA_MONITOR -- requirements
Module: nivel_agua_monitor

---
 rtl/nivel_agua_monitor_if.sv | 25 ++
 rtl/nivel_agua_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_nivel_agua_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nivel_agua_monitor_if.sv
// Probe inputs, control strobes and monitor outputs of the water-level monitor.
interface nivel_agua_monitor_if #(
   parameter int N_SENS = 3
);
   logic [N_SENS-1:0] probe;
   logic              sample_en;
   logic              fault_clr;
   logic [3:0]        level;
   logic [6:0]        seg;
   logic              pump_on;
   logic              irrig_ok;
   logic              fault;
   logic [1:0]        fault_code;
   logic              level_chg;

   modport master (
      output probe, sample_en, fault_clr,
      input  level, seg, pump_on, irrig_ok, fault, fault_code, level_chg
   );

   modport slave (
      input  probe, sample_en, fault_clr,
      output level, seg, pump_on, irrig_ok, fault, fault_code, level_chg
   );
endinterface

// File: rtl/nivel_agua_monitor.sv
// Tank level monitor: synchronises and debounces the probe string, derives the
// level, runs the fill pump with hysteresis and latches pattern/timeout faults.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | tank above refill threshold, pump off
// ST_FILLING | pump on until the top probe is wet; timeout armed
// ST_FAULT   | latched fault, pump and irrigation blocked, 'F' shown
module nivel_agua_monitor #(
   parameter int N_SENS     = 3,
   parameter int DEB_CYCLES = 4,
   parameter int LOW_LVL    = 1,
   parameter int FILL_TMO   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   nivel_agua_monitor_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILLING = 2'd1,
      ST_FAULT   = 2'd2
   } state_e;

   localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYCLES - 1);
   localparam logic [15:0] TMO_LAST  = 16'(FILL_TMO - 1);
   localparam logic [3:0]  FULL_LVL  = 4'(N_SENS);
   localparam logic [3:0]  LOW_LVL_C = 4'(LOW_LVL);
   localparam logic [6:0]  SEG_F     = 7'b1000111;
   localparam logic [1:0]  CODE_NONE = 2'b00;
   localparam logic [1:0]  CODE_PAT  = 2'b01;
   localparam logic [1:0]  CODE_TMO  = 2'b10;

   function automatic logic [3:0] popcnt(input logic [N_SENS-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < N_SENS; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] lvl);
      logic [6:0] s;
      case (lvl)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   logic [N_SENS-1:0]       sync1_q, sync2_q;
   logic [N_SENS-1:0]       filt_q, filt_d;
   logic [N_SENS-1:0][7:0]  deb_cnt_q, deb_cnt_d;
   logic [N_SENS:0]         filt_ext;
   logic                    filt_valid;
   logic [3:0]              filt_pop;
   logic [3:0]              level_q, level_d;
   logic                    level_chg_q, level_chg_d;
   logic                    level_inc;
   logic [15:0]             tmo_q, tmo_d;
   logic                    tmo_hit;
   logic                    fault_q, fault_d;
   logic [1:0]              code_q, code_d;
   state_e                  state_q, state_d;
   logic                    pump_q, pump_d;
   logic                    irrig_q, irrig_d;
   logic [6:0]              seg_q, seg_d;

   // Per-probe debounce: a differing sample must persist for DEB_CYCLES ticks.
   always_comb begin
      filt_d    = filt_q;
      deb_cnt_d = deb_cnt_q;
      for (int i = 0; i < N_SENS; i++) begin
         if (sync2_q[i] == filt_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (bus.sample_en) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               filt_d[i]    = sync2_q[i];
               deb_cnt_d[i] = '0;
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
            end
         end
      end
   end

   // Synchroniser chain, filtered probes and debounce counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         filt_q    <= '0;
         deb_cnt_q <= '0;
      end else begin
         sync1_q   <= bus.probe;
         sync2_q   <= sync1_q;
         filt_q    <= filt_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   // Thermometer check, level tracking, fill timeout and fault latch.
   always_comb begin
      filt_ext    = {1'b0, filt_q};
      filt_valid  = ((filt_ext & (filt_ext + {{N_SENS{1'b0}}, 1'b1})) == '0);
      filt_pop    = popcnt(filt_q);
      level_d     = filt_valid ? filt_pop : level_q;
      level_chg_d = (level_d != level_q);
      level_inc   = filt_valid && (filt_pop > level_q);

      tmo_hit = (state_q == ST_FILLING) && !level_inc && bus.sample_en && (tmo_q == TMO_LAST);
      tmo_d   = tmo_q;
      if ((state_q != ST_FILLING) || level_inc || tmo_hit) begin
         tmo_d = '0;
      end else if (bus.sample_en) begin
         tmo_d = tmo_q + 16'd1;
      end

      // First cause sticks; a bad pattern outranks a simultaneous timeout.
      fault_d = fault_q;
      code_d  = code_q;
      if (fault_q) begin
         if (bus.fault_clr && filt_valid) begin
            fault_d = 1'b0;
            code_d  = CODE_NONE;
         end
      end else if (!filt_valid) begin
         fault_d = 1'b1;
         code_d  = CODE_PAT;
      end else if (tmo_hit) begin
         fault_d = 1'b1;
         code_d  = CODE_TMO;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q     <= '0;
         level_chg_q <= 1'b0;
         tmo_q       <= '0;
         fault_q     <= 1'b0;
         code_q      <= CODE_NONE;
      end else begin
         level_q     <= level_d;
         level_chg_q <= level_chg_d;
         tmo_q       <= tmo_d;
         fault_q     <= fault_d;
         code_q      <= code_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a latched fault overrides the level-driven transitions.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (level_q <= LOW_LVL_C) state_d = ST_FILLING;
         ST_FILLING: if (level_q == FULL_LVL)  state_d = ST_IDLE;
         ST_FAULT:   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      if (fault_d) begin
         state_d = ST_FAULT;
      end
   end

   // FSM outputs, computed from next state/level so the registers line up with them.
   always_comb begin
      pump_d  = (state_d == ST_FILLING);
      irrig_d = (state_d != ST_FAULT) && (level_d != 4'd0);
      seg_d   = (state_d == ST_FAULT) ? SEG_F : seg_of(level_d);
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pump_q  <= 1'b0;
         irrig_q <= 1'b0;
         seg_q   <= 7'b1111110;
      end else begin
         pump_q  <= pump_d;
         irrig_q <= irrig_d;
         seg_q   <= seg_d;
      end
   end

   assign bus.level      = level_q;
   assign bus.level_chg  = level_chg_q;
   assign bus.fault      = fault_q;
   assign bus.fault_code = code_q;
   assign bus.pump_on    = pump_q;
   assign bus.irrig_ok   = irrig_q;
   assign bus.seg        = seg_q;

endmodule

// File: tb/tb_nivel_agua_monitor.sv
// Directed bench for the water-level monitor: default 3-probe instance plus an 8-probe instance.
module tb_nivel_agua_monitor;

   localparam logic [6:0] S0 = 7'b1111110;
   localparam logic [6:0] S1 = 7'b0110000;
   localparam logic [6:0] S2 = 7'b1101101;
   localparam logic [6:0] S3 = 7'b1111001;
   localparam logic [6:0] S8 = 7'b1111111;
   localparam logic [6:0] SF = 7'b1000111;

   typedef struct {
      logic [2:0] probe;
      int         hold;
      logic [3:0] lvl;
      logic       pump;
      logic       irrig;
      logic       flt;
      logic [1:0] code;
      logic [6:0] seg;
   } vec_t;

   logic clk;
   logic rst3, rst8;
   int   n_checks, n_err;
   int   chg_cnt;
   vec_t vec [6];

   nivel_agua_monitor_if #(.N_SENS(3)) bus3 ();
   nivel_agua_monitor_if #(.N_SENS(8)) bus8 ();

   nivel_agua_monitor #(.N_SENS(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));
   nivel_agua_monitor #(.N_SENS(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [3:0] lvl, input logic pump,
                            input logic irrig, input logic flt, input logic [1:0] code,
                            input logic [6:0] seg);
      check({name, "_level"},    32'(bus3.level),      32'(lvl));
      check({name, "_pump"},     32'(bus3.pump_on),    32'(pump));
      check({name, "_irrig"},    32'(bus3.irrig_ok),   32'(irrig));
      check({name, "_fault"},    32'(bus3.fault),      32'(flt));
      check({name, "_code"},     32'(bus3.fault_code), 32'(code));
      check({name, "_seg"},      32'(bus3.seg),        32'(seg));
   endtask

   task automatic pulse_clr();
      bus3.fault_clr = 1'b1;
      tick();
      bus3.fault_clr = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      //        probe   hold lvl pump irrig flt code seg
      vec[0] = '{3'b001,  9, 4'd1, 1'b1, 1'b1, 1'b0, 2'd0, S1};
      vec[1] = '{3'b011,  9, 4'd2, 1'b1, 1'b1, 1'b0, 2'd0, S2};
      vec[2] = '{3'b111,  9, 4'd3, 1'b0, 1'b1, 1'b0, 2'd0, S3};
      vec[3] = '{3'b011,  9, 4'd2, 1'b0, 1'b1, 1'b0, 2'd0, S2};
      vec[4] = '{3'b001,  9, 4'd1, 1'b1, 1'b1, 1'b0, 2'd0, S1};
      vec[5] = '{3'b001, 12, 4'd1, 1'b0, 1'b0, 1'b1, 2'd2, SF};

      rst3 = 1'b1;
      rst8 = 1'b1;
      bus3.probe = '0; bus3.sample_en = 1'b1; bus3.fault_clr = 1'b0;
      bus8.probe = '0; bus8.sample_en = 1'b1; bus8.fault_clr = 1'b0;
      repeat (3) tick();

      check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, S0);
      check("reset_chg", 32'(bus3.level_chg), 32'd0);

      rst3 = 1'b0;
      tick();
      check("release_pump", 32'(bus3.pump_on), 32'd1);

      // Hysteresis sweep 0->3->2->1, then sit at level 1 until the fill timeout.
      for (int i = 0; i < 6; i++) begin
         bus3.probe = vec[i].probe;
         repeat (vec[i].hold) tick();
         check_all($sformatf("vec%0d", i), vec[i].lvl, vec[i].pump, vec[i].irrig,
                   vec[i].flt, vec[i].code, vec[i].seg);
      end

      // Clear with valid probes: IDLE then FILLING, then exact 10-tick timeout.
      pulse_clr();
      check_all("clr_tmo", 4'd1, 1'b0, 1'b1, 1'b0, 2'd0, S1);
      tick();
      check("refill_pump", 32'(bus3.pump_on), 32'd1);
      repeat (9) tick();
      check("tmo_9ticks_fault", 32'(bus3.fault), 32'd0);
      tick();
      check("tmo_10ticks_fault", 32'(bus3.fault), 32'd1);
      check("tmo_10ticks_code", 32'(bus3.fault_code), 32'd2);

      // Level keeps tracking while in FAULT; first cause retained over a later bad pattern.
      bus3.probe = 3'b111;
      repeat (9) tick();
      check_all("fault_lvl3", 4'd3, 1'b0, 1'b0, 1'b1, 2'd2, SF);
      bus3.probe = 3'b101;
      repeat (9) tick();
      check("keep_first_code", 32'(bus3.fault_code), 32'd2);
      pulse_clr();
      check("clr_blocked_tmo", 32'(bus3.fault), 32'd1);
      bus3.probe = 3'b111;
      repeat (9) tick();
      pulse_clr();
      check_all("clr_to_idle3", 4'd3, 1'b0, 1'b1, 1'b0, 2'd0, S3);

      // Invalid pattern 101 from level 3.
      bus3.probe = 3'b101;
      repeat (6) tick();
      check("inv_not_yet", 32'(bus3.fault), 32'd0);
      tick();
      check_all("inv_fault", 4'd3, 1'b0, 1'b0, 1'b1, 2'd1, SF);
      pulse_clr();
      check("clr_blocked_inv", 32'(bus3.fault), 32'd1);
      check("clr_blocked_inv_code", 32'(bus3.fault_code), 32'd1);
      bus3.probe = 3'b111;
      repeat (9) tick();
      pulse_clr();
      check_all("clr_inv", 4'd3, 1'b0, 1'b1, 1'b0, 2'd0, S3);

      // Debounce: 3-cycle glitch ignored, 6-cycle hold accepted.
      chg_cnt = 0;
      bus3.probe = 3'b011;
      repeat (3) begin tick(); chg_cnt += int'(bus3.level_chg); end
      bus3.probe = 3'b111;
      repeat (9) begin tick(); chg_cnt += int'(bus3.level_chg); end
      check("glitch_level", 32'(bus3.level), 32'd3);
      check("glitch_chg", 32'(chg_cnt), 32'd0);
      bus3.probe = 3'b011;
      repeat (6) begin tick(); chg_cnt += int'(bus3.level_chg); end
      check("deb6_level", 32'(bus3.level), 32'd3);
      check("deb6_chg", 32'(chg_cnt), 32'd0);
      tick();
      check_all("deb7", 4'd2, 1'b0, 1'b1, 1'b0, 2'd0, S2);
      check("deb7_chg", 32'(bus3.level_chg), 32'd1);
      tick();
      check("deb8_chg", 32'(bus3.level_chg), 32'd0);

      // Reset during FILLING at level 2.
      bus3.probe = 3'b001;
      repeat (9) tick();
      bus3.probe = 3'b011;
      repeat (9) tick();
      check_all("fill_lvl2", 4'd2, 1'b1, 1'b1, 1'b0, 2'd0, S2);
      rst3 = 1'b1;
      tick();
      check_all("midrst", 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, S0);
      check("midrst_chg", 32'(bus3.level_chg), 32'd0);
      rst3 = 1'b0;

      // Eight-probe instance filled to the top.
      bus8.probe = 8'hFF;
      rst8 = 1'b0;
      tick();
      check("n8_pump_start", 32'(bus8.pump_on), 32'd1);
      repeat (9) tick();
      check("n8_level", 32'(bus8.level), 32'd8);
      check("n8_seg", 32'(bus8.seg), 32'(S8));
      check("n8_pump_full", 32'(bus8.pump_on), 32'd0);
      check("n8_irrig", 32'(bus8.irrig_ok), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
